// File: rtl/rd_addr_gen_ctrl.sv
// Read-side address generator for a synchronous-RAM FIFO: owns the read pointer,
// derives occupancy/empty flags from the write pointer, and flags reads on empty.
module rd_addr_gen_ctrl #(
  parameter int FIFO_PTR_WIDE = 3,
  parameter int AE_LEVEL      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [FIFO_PTR_WIDE:0]   wr_ptr,
  input  logic                     err_clr,
  output logic [FIFO_PTR_WIDE-1:0] rd_addr,
  output logic [FIFO_PTR_WIDE:0]   rd_ptr,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [FIFO_PTR_WIDE:0]   level,
  output logic                     underflow
);

  localparam int PW = FIFO_PTR_WIDE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] level_w;
  logic          empty_w;
  logic          rd_accept;

  // Empty is judged on the current write pointer only, so a write landing on the
  // same edge cannot rescue a read issued while empty.
  always_comb begin
    level_w     = wr_ptr - rd_ptr_q;
    empty_w     = (level_w == '0);
    rd_accept   = rd_en & ~empty_w;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = rd_accept;
    underflow_d = underflow_q & ~err_clr;
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (rd_en && empty_w) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_ptr       = rd_ptr_q;
  assign rd_addr      = rd_ptr_q[FIFO_PTR_WIDE-1:0];
  assign rd_valid     = rd_valid_q;
  assign underflow    = underflow_q;
  assign level        = level_w;
  assign empty        = empty_w;
  assign almost_empty = (level_w <= AE_LVL);

endmodule

// File: tb/tb_rd_addr_gen_ctrl.sv
// Directed bench for rd_addr_gen_ctrl (W=3, AE_LEVEL=1): expected read addresses are
// queued at issue and matched by a monitor against each rd_valid.
module tb_rd_addr_gen_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] wr_ptr;
  logic       err_clr;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [3:0] level;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  rd_addr_gen_ctrl #(.FIFO_PTR_WIDE(3), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_ptr       (wr_ptr),
    .err_clr      (err_clr),
    .rd_addr      (rd_addr),
    .rd_ptr       (rd_ptr),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Full status check from a hand-computed pointer/level; flags follow from level.
  task automatic st(input string tag, input int ptr, input int lvl, input int vld, input int uf);
    chk({tag, ".rd_ptr"},       int'(rd_ptr), ptr);
    chk({tag, ".rd_addr"},      int'(rd_addr), ptr % 8);
    chk({tag, ".level"},        int'(level), lvl);
    chk({tag, ".empty"},        int'(empty), (lvl == 0) ? 1 : 0);
    chk({tag, ".almost_empty"}, int'(almost_empty), (lvl <= 1) ? 1 : 0);
    chk({tag, ".rd_valid"},     int'(rd_valid), vld);
    chk({tag, ".underflow"},    int'(underflow), uf);
  endtask

  task automatic step(input logic rd, input int wr, input logic clr, input logic push, input int addr);
    @(posedge clk);
    #1;
    rd_en   = rd;
    wr_ptr  = 4'(wr);
    err_clr = clr;
    if (push) exp_q.push_back(addr);
    #1;
  endtask

  // Monitor: each rd_valid must match the next queued address, i.e. the address
  // the DUT presented in the acceptance cycle.
  initial begin
    int last_addr;
    int e;
    last_addr = -1;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 expected no pending read at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb.read_addr", last_addr, e);
        end
      end
      if (rst_n && rd_en && !empty) last_addr = int'(rd_addr);
    end
  end

  initial begin
    rst_n   = 1'b0;
    rd_en   = 1'b0;
    wr_ptr  = 4'd0;
    err_clr = 1'b0;
    #2;
    st("reset", 0, 0, 0, 0);
    #10 rst_n = 1'b1;

    step(0, 8, 0, 0, 0); st("full", 0, 8, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 8, 0, 1, i);
      st("burst", i, 8 - i, (i > 0) ? 1 : 0, 0);
    end
    step(0, 8, 0, 0, 0); st("drained", 8, 0, 1, 0);

    step(1, 8, 0, 0, 0); st("uf_req", 8, 0, 0, 0);
    step(0, 8, 0, 0, 0); st("uf_set", 8, 0, 0, 1);
    step(0, 8, 1, 0, 0); st("uf_clr_req", 8, 0, 0, 1);
    step(0, 8, 0, 0, 0); st("uf_cleared", 8, 0, 0, 0);
    step(1, 8, 1, 0, 0); st("uf_clr_and_rd", 8, 0, 0, 0);
    step(0, 8, 0, 0, 0); st("uf_new_wins", 8, 0, 0, 1);
    step(0, 8, 1, 0, 0); st("uf_clr2_req", 8, 0, 0, 1);
    step(0, 8, 0, 0, 0); st("uf_clr2", 8, 0, 0, 0);

    step(0, 9, 0, 0, 0);  st("lvl1", 8, 1, 0, 0);
    step(1, 9, 0, 1, 0);  st("lvl1_rdwr", 8, 1, 0, 0);
    step(0, 10, 0, 0, 0); st("lvl1_after", 9, 1, 1, 0);
    step(1, 10, 0, 1, 1); st("lvl1_drain", 9, 1, 0, 0);
    step(0, 10, 0, 0, 0); st("empty_again", 10, 0, 1, 0);
    step(1, 10, 0, 0, 0); st("empty_rdwr", 10, 0, 0, 0);
    step(0, 11, 0, 0, 0); st("empty_rdwr_after", 10, 1, 0, 1);
    step(0, 11, 1, 0, 0); st("uf_clr3_req", 10, 1, 0, 1);
    step(0, 11, 0, 0, 0); st("uf_clr3", 10, 1, 0, 0);

    step(0, 15, 0, 0, 0); st("pre_wrap", 10, 5, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 15, 0, 1, 2 + k);
      st("to_wrap", 10 + k, 5 - k, (k > 0) ? 1 : 0, 0);
    end
    step(0, 1, 0, 0, 0); st("wrap_pre", 15, 2, 1, 0);
    step(1, 1, 0, 1, 7); st("wrap_rd", 15, 2, 0, 0);
    step(0, 1, 0, 0, 0); st("wrap_post", 0, 1, 1, 0);
    step(1, 1, 0, 1, 0); st("wrap_drain", 0, 1, 0, 0);
    step(0, 1, 0, 0, 0); st("wrap_empty", 1, 0, 1, 0);

    step(0, 7, 0, 0, 0); st("rst_lvl6", 1, 6, 0, 0);
    step(1, 7, 0, 1, 1); st("rst_burst0", 1, 6, 0, 0);
    step(1, 7, 0, 1, 2); st("rst_burst1", 2, 5, 1, 0);
    step(1, 7, 0, 0, 0); st("rst_burst2", 3, 4, 1, 0);
    #5 rst_n = 1'b0;
    #1 st("rst_async", 0, 7, 0, 0);
    rd_en  = 1'b0;
    wr_ptr = 4'd0;
    #1 st("rst_held", 0, 0, 0, 0);
    @(posedge clk);
    #1 st("rst_edge", 0, 0, 0, 0);
    #6 rst_n = 1'b1;
    step(0, 0, 0, 0, 0); st("rst_release", 0, 0, 0, 0);
    step(1, 2, 0, 1, 0); st("post_rst_rd", 0, 2, 0, 0);
    step(0, 2, 0, 0, 0); st("post_rst_acc", 1, 1, 1, 0);
    step(0, 2, 0, 0, 0); st("post_rst_idle", 1, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1 chk("sb.pending_reads", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
